// File: rtl/dsp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_cmd_sequencer
//   Command front-end for a single DSP48E1 slice. The slice is configured with
//   AREG=BREG=CREG=1, INMODEREG=OPMODEREG=ALUMODEREG=1, MREG=0 and PREG=1.
//   Ops arrive over a valid/ready handshake. Each op drives registered
//   A/B/C/OPMODE/ALUMODE values to the slice. A tag pipe follows each op through
//   the slice pipeline, and P is captured into an ordered result FIFO when that
//   op's result is valid. On idle cycles the slice is held with P=P, so a MAC
//   chain keeps its value across gaps in the command stream.
//
// Configuration macro:
//   DSP_SAT_EN  When defined, results are clamped to SAT_W-bit signed range
//               on FIFO write and res_sat flags the clamped entries.
//               When undefined, dsp_p is stored raw and res_sat stays 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=MUL 1=MAC 2=ADD 3=SUB
//   cmd_a/cmd_b/cmd_c     operands (30/18/48 bits)
//   res_valid/res_ready   result handshake (FIFO head)
//   res_data, res_sat     result value and clamp flag
//   busy                  any op in flight or any result queued
//   dsp_a/b/c             slice A/B/C inputs
//   dsp_inmode            slice INMODE, tied to zero
//   dsp_opmode            slice OPMODE
//   dsp_alumode           slice ALUMODE
//   dsp_p                 slice P output
// -----------------------------------------------------------------------------
module dsp_cmd_sequencer #(
  parameter int unsigned DSP_LAT   = 2,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned SAT_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [29:0] cmd_a,
  input  logic [17:0] cmd_b,
  input  logic [47:0] cmd_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic        res_sat,
  output logic        busy,
  output logic [29:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [47:0] dsp_c,
  output logic [4:0]  dsp_inmode,
  output logic [6:0]  dsp_opmode,
  output logic [3:0]  dsp_alumode,
  input  logic [47:0] dsp_p
);

  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RES_DEPTH);

  // OPMODE = {Z[2:0], Y[1:0], X[1:0]}
  localparam logic [6:0] OPM_HOLD = 7'b010_00_00;  // P = P
  localparam logic [6:0] OPM_MUL  = 7'b000_01_01;  // P = A*B
  localparam logic [6:0] OPM_MAC  = 7'b010_01_01;  // P = P + A*B
  localparam logic [6:0] OPM_CAB  = 7'b011_00_11;  // P = C +/- A:B
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0011;       // Z - (X+Y+CIN)

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_MAC = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RES_DEPTH must be a power of two and at least 2");
  end
  if (DSP_LAT < 1) begin : g_bad_lat
    $error("DSP_LAT must be at least 1");
  end
  if (SAT_W < 2 || SAT_W > 48) begin : g_bad_sat
    $error("SAT_W must be in 2..48");
  end

  // Slice drive registers
  logic [29:0] dsp_a_q, dsp_a_d;
  logic [17:0] dsp_b_q, dsp_b_d;
  logic [47:0] dsp_c_q, dsp_c_d;
  logic [6:0]  dsp_opmode_q, dsp_opmode_d;
  logic [3:0]  dsp_alumode_q, dsp_alumode_d;

  // Bit 0 marks an op whose controls are on the sequencer outputs; bits
  // 1..DSP_LAT follow it through the slice registers. The top bit is set
  // for exactly the cycle in which P holds that op's result.
  logic [DSP_LAT:0] tag_q, tag_d;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [47:0]      mem_q [RES_DEPTH];

  logic        accept;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [47:0] wr_data;

  // ---------------------------------------------------------------------------
  // Handshake, credit and tag pipe
  // ---------------------------------------------------------------------------
  always_comb begin
    accept   = cmd_valid && cmd_ready_q;
    fifo_wr  = tag_q[DSP_LAT];
    fifo_rd  = res_ready && (count_q != '0);
    tag_d    = {tag_q[DSP_LAT-1:0], accept};

    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(fifo_wr);
    count_d    = count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

    // Registering the credit test on the next-state counts gives the same
    // value as testing the registered counts combinationally, so a pop only
    // returns its credit on the following cycle.
    cmd_ready_d = ({1'b0, inflight_d} + {1'b0, count_d}) < DEPTH_C;

    wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // ---------------------------------------------------------------------------
  // Slice control: load on accept, otherwise HOLD so P keeps its value.
  // A/B/C keep their last values; HOLD ignores them.
  // ---------------------------------------------------------------------------
  always_comb begin
    dsp_a_d       = dsp_a_q;
    dsp_b_d       = dsp_b_q;
    dsp_c_d       = dsp_c_q;
    dsp_opmode_d  = OPM_HOLD;
    dsp_alumode_d = ALU_ADD;
    if (accept) begin
      dsp_a_d = cmd_a;
      dsp_b_d = cmd_b;
      dsp_c_d = cmd_c;
      case (op_e'(cmd_op))
        OP_MUL: dsp_opmode_d = OPM_MUL;
        OP_MAC: dsp_opmode_d = OPM_MAC;
        OP_ADD: dsp_opmode_d = OPM_CAB;
        OP_SUB: begin
          dsp_opmode_d  = OPM_CAB;
          dsp_alumode_d = ALU_SUB;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture, with optional saturation
  // ---------------------------------------------------------------------------
`ifdef DSP_SAT_EN
  localparam logic signed [47:0] SAT_MAX = {{(49 - SAT_W){1'b0}}, {(SAT_W - 1){1'b1}}};
  localparam logic signed [47:0] SAT_MIN = {{(49 - SAT_W){1'b1}}, {(SAT_W - 1){1'b0}}};

  logic wr_sat;
  logic sat_q [RES_DEPTH];

  always_comb begin
    wr_data = dsp_p;
    wr_sat  = 1'b0;
    if ($signed(dsp_p) > SAT_MAX) begin
      wr_data = SAT_MAX;
      wr_sat  = 1'b1;
    end else if ($signed(dsp_p) < SAT_MIN) begin
      wr_data = SAT_MIN;
      wr_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '{default: 1'b0};
    end else if (fifo_wr) begin
      sat_q[wr_ptr_q] <= wr_sat;
    end
  end

  assign res_sat = sat_q[rd_ptr_q];
`else
  always_comb begin
    wr_data = dsp_p;
  end

  assign res_sat = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a_q       <= '0;
      dsp_b_q       <= '0;
      dsp_c_q       <= '0;
      dsp_opmode_q  <= OPM_HOLD;
      dsp_alumode_q <= '0;
      tag_q         <= '0;
      inflight_q    <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_q         <= '{default: '0};
    end else begin
      dsp_a_q       <= dsp_a_d;
      dsp_b_q       <= dsp_b_d;
      dsp_c_q       <= dsp_c_d;
      dsp_opmode_q  <= dsp_opmode_d;
      dsp_alumode_q <= dsp_alumode_d;
      tag_q         <= tag_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (fifo_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = (count_q != '0);
  assign res_data    = mem_q[rd_ptr_q];
  assign busy        = (inflight_q != '0) || res_valid;
  assign dsp_a       = dsp_a_q;
  assign dsp_b       = dsp_b_q;
  assign dsp_c       = dsp_c_q;
  assign dsp_inmode  = '0;
  assign dsp_opmode  = dsp_opmode_q;
  assign dsp_alumode = dsp_alumode_q;

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
module tb_dsp_cmd_sequencer;

  localparam int unsigned RES_DEPTH = 4;
  localparam logic [6:0]  HOLD      = 7'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [29:0] cmd_a = '0;
  logic [17:0] cmd_b = '0;
  logic [47:0] cmd_c = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_data;
  logic        res_sat;
  logic        busy;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [47:0] dsp_c;
  logic [4:0]  dsp_inmode;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [47:0] dsp_p = '0;

  always #5 clk = ~clk;

  dsp_cmd_sequencer #(
    .DSP_LAT  (2),
    .RES_DEPTH(RES_DEPTH),
    .SAT_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_c      (cmd_c),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sat    (res_sat),
    .busy       (busy),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_c      (dsp_c),
    .dsp_inmode (dsp_inmode),
    .dsp_opmode (dsp_opmode),
    .dsp_alumode(dsp_alumode),
    .dsp_p      (dsp_p)
  );

  // ---------------------------------------------------------------------------
  // DSP48E1 slice: input/control registers, combinational multiplier, P reg.
  // Not reset by rst_n.
  // ---------------------------------------------------------------------------
  logic [29:0] sa = '0;
  logic [17:0] sb = '0;
  logic [47:0] sc = '0;
  logic [6:0]  sop = 7'h20;
  logic [3:0]  salu = '0;

  function automatic logic [47:0] slice_p(input logic [29:0] a, input logic [17:0] b,
                                          input logic [47:0] c, input logic [6:0] op,
                                          input logic [3:0] alu, input logic [47:0] p);
    logic [47:0] ma, mb, xy, z;
    ma = {{23{a[24]}}, a[24:0]};
    mb = {{30{b[17]}}, b};
    xy = '0;
    if (op[3:0] == 4'b0101) xy = ma * mb;
    else if (op[1:0] == 2'b11) xy = {a, b};
    case (op[6:4])
      3'b010:  z = p;
      3'b011:  z = c;
      default: z = '0;
    endcase
    return (alu == 4'b0011) ? z - xy : z + xy;
  endfunction

  always @(posedge clk) begin
    sa    <= dsp_a;
    sb    <= dsp_b;
    sc    <= dsp_c;
    sop   <= dsp_opmode;
    salu  <= dsp_alumode;
    dsp_p <= slice_p(sa, sb, sc, sop, salu, dsp_p);
  end

  // ---------------------------------------------------------------------------
  // Reference model: accumulator semantics per op, ordered result queue with
  // the time each result becomes visible.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [47:0] data;
    logic        sat;
    int          vis;
  } res_t;

  typedef struct packed {
    logic [47:0] d;
    logic        s;
  } pop_t;

  typedef struct {
    logic [1:0]  op;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] exp;
    logic        exp_sat;
  } vec_t;

  res_t        mq[$];
  pop_t        dut_pops[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [47:0] acc = '0;
  logic [6:0]  exp_opm = HOLD;
  logic [3:0]  exp_alu = '0;
  logic        acc_seen = 1'b0;

  function automatic logic [47:0] ref_exec(input logic [1:0] op, input logic [29:0] a,
                                           input logic [17:0] b, input logic [47:0] c,
                                           input logic [47:0] acc_in);
    logic signed [47:0] pa, pb, prod;
    pa   = {{23{a[24]}}, a[24:0]};
    pb   = {{30{b[17]}}, b};
    prod = pa * pb;
    case (op)
      2'd0:    return prod;
      2'd1:    return acc_in + prod;
      2'd2:    return c + {a, b};
      default: return c - {a, b};
    endcase
  endfunction

  function automatic res_t make_res(input logic [47:0] v, input int vis);
    res_t r;
    r.data = v;
    r.sat  = 1'b0;
    r.vis  = vis;
`ifdef DSP_SAT_EN
    if ($signed(v) > 48'sd2147483647) begin
      r.data = 48'h0000_7FFF_FFFF;
      r.sat  = 1'b1;
    end else if ($signed(v) < -48'sd2147483648) begin
      r.data = 48'hFFFF_8000_0000;
      r.sat  = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic logic [6:0] opm_of(input logic [1:0] op);
    case (op)
      2'd0:    return 7'b000_01_01;
      2'd1:    return 7'b010_01_01;
      default: return 7'b011_00_11;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // across the rising edge using the inputs that were applied.
  task automatic step();
    logic ev, er, da, dp;
    pop_t pp;
    @(negedge clk);
    ev = (mq.size() > 0) && (mq[0].vis <= cyc);
    er = (mq.size() < RES_DEPTH);
    chk("res_valid", res_valid, ev);
    chk("cmd_ready", cmd_ready, er);
    chk("busy", busy, mq.size() != 0);
    chk("dsp_opmode", dsp_opmode, exp_opm);
    chk("dsp_alumode", dsp_alumode, exp_alu);
    chk("dsp_inmode", dsp_inmode, 5'd0);
    if (ev) begin
      chk("res_data", res_data, mq[0].data);
      chk("res_sat", res_sat, mq[0].sat);
    end
    acc_seen = cmd_valid && cmd_ready;
    if (res_valid === 1'b1 && res_ready) begin
      pp.d = res_data;
      pp.s = res_sat;
      dut_pops.push_back(pp);
    end
    da = cmd_valid && er;
    dp = ev && res_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (dp) void'(mq.pop_front());
    exp_opm = HOLD;
    exp_alu = '0;
    if (da) begin
      acc = ref_exec(cmd_op, cmd_a, cmd_b, cmd_c, acc);
      mq.push_back(make_res(acc, cyc + 3));
      exp_opm = opm_of(cmd_op);
      exp_alu = (cmd_op == 2'd3) ? 4'b0011 : 4'b0000;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_opmode", dsp_opmode, 7'h20);
    chk("rst_alumode", dsp_alumode, 4'h0);
    chk("rst_dsp_a", dsp_a, 30'h0);
    chk("rst_res_data", res_data, 48'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    dut_pops.delete();
    exp_opm = HOLD;
    exp_alu = '0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [29:0] a, input logic [17:0] b,
                       input logic [47:0] c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t tbl[9];
    int   n;
    int   idx;
    int   base;
    bit   first_done;

    // op, a, b, c, expected, expected sat
    tbl[0] = '{2'd0, 30'd3, 18'h3FFFB, 48'd0, 48'hFFFF_FFFF_FFF1, 1'b0};
    tbl[1] = '{2'd2, 30'd0, 18'd5, 48'd100, 48'd105, 1'b0};
    tbl[2] = '{2'd3, 30'd0, 18'd5, 48'd100, 48'd95, 1'b0};
    tbl[3] = '{2'd1, 30'd2, 18'd3, 48'd0, 48'd101, 1'b0};
    tbl[4] = '{2'd2, 30'd1, 18'd0, 48'd0, 48'h0000_0004_0000, 1'b0};
    tbl[5] = '{2'd3, 30'd0, 18'd1, 48'd0, 48'hFFFF_FFFF_FFFF, 1'b0};
    tbl[6] = '{2'd1, 30'h3FFF_FFFF, 18'd1, 48'd0, 48'hFFFF_FFFF_FFFE, 1'b0};
`ifdef DSP_SAT_EN
    tbl[7] = '{2'd0, 30'h0010_0000, 18'h08000, 48'd0, 48'h0000_7FFF_FFFF, 1'b1};
    tbl[8] = '{2'd0, 30'h3FF0_0000, 18'h08000, 48'd0, 48'hFFFF_8000_0000, 1'b1};
`else
    tbl[7] = '{2'd0, 30'h0010_0000, 18'h08000, 48'd0, 48'h0008_0000_0000, 1'b0};
    tbl[8] = '{2'd0, 30'h3FF0_0000, 18'h08000, 48'd0, 48'hFFF8_0000_0000, 1'b0};
`endif

    // Reset state
    do_reset();
    step();

    // Single ops from the table, one at a time
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c);
      step();
      chk("tbl_accept", acc_seen, 1'b1);
      cmd_valid = 1'b0;
      base = dut_pops.size();
      n = 0;
      while (dut_pops.size() == base && n < 12) begin
        step();
        n++;
      end
      if (dut_pops.size() == base) begin
        chk("tbl_timeout", 1'b0, 1'b1);
      end else begin
        chk("tbl_data", dut_pops[base].d, tbl[i].exp);
        chk("tbl_sat", dut_pops[base].s, tbl[i].exp_sat);
        // result visible 3 cycles after accept, popped on the following edge
        chk("tbl_latency", n, 4);
      end
    end

    // Back-to-back MUL, MAC; idle gap; MAC continues the chain
    do_reset();
    res_ready = 1'b1;
    drive(2'd0, 30'd2, 18'd3, 48'd0);
    step();
    drive(2'd1, 30'd4, 18'd5, 48'd0);
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    drive(2'd1, 30'd1, 18'd1, 48'd0);
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (dut_pops.size() < 3 && n < 15) begin
      step();
      n++;
    end
    chk("b2b_count", dut_pops.size(), 3);
    if (dut_pops.size() >= 3) begin
      chk("b2b_r0", dut_pops[0].d, 48'd6);
      chk("b2b_r1", dut_pops[1].d, 48'd26);
      chk("b2b_r2", dut_pops[2].d, 48'd27);
    end

    // Credit limit: six commands offered with the result side stalled
    do_reset();
    res_ready = 1'b0;
    idx = 0;
    for (int s = 0; s < 10; s++) begin
      if (idx < 6) drive(2'd0, 30'(idx + 1), 18'd10, 48'd0);
      else cmd_valid = 1'b0;
      step();
      if (acc_seen) idx++;
    end
    chk("full_accepts", idx, 4);
    chk("full_ready", cmd_ready, 1'b0);
    res_ready = 1'b1;
    n = 0;
    while (dut_pops.size() < 6 && n < 40) begin
      if (idx < 6) drive(2'd0, 30'(idx + 1), 18'd10, 48'd0);
      else cmd_valid = 1'b0;
      step();
      if (acc_seen) idx++;
      n++;
    end
    cmd_valid = 1'b0;
    chk("full_pops", dut_pops.size(), 6);
    for (int i = 0; i < 6 && i < dut_pops.size(); i++) begin
      chk("full_order", dut_pops[i].d, 48'((i + 1) * 10));
    end

    // Reset one cycle after an accept: the op must vanish
    do_reset();
    res_ready = 1'b1;
    drive(2'd0, 30'd7, 18'd9, 48'd0);
    step();
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", res_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    exp_opm = HOLD;
    exp_alu = '0;
    repeat (8) step();
    chk("midrst_no_result", dut_pops.size(), 0);

    // Randomized traffic against the model
    do_reset();
    first_done = 1'b0;
    cmd_valid  = 1'b0;
    for (int s = 0; s < 400; s++) begin
      if (!cmd_valid || acc_seen) begin
        cmd_valid = ($urandom_range(9) < 7);
        cmd_op    = first_done ? 2'($urandom) : 2'd0;
        cmd_a     = ($urandom_range(3) == 0) ? 30'($urandom_range(15)) : 30'($urandom);
        cmd_b     = 18'($urandom);
        cmd_c     = {16'($urandom), 32'($urandom)};
      end
      res_ready = ($urandom_range(9) < 6);
      acc_seen  = 1'b0;
      step();
      if (acc_seen) first_done = 1'b1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 30) begin
      step();
      n++;
    end
    chk("rand_drained", mq.size(), 0);
    step();
    chk("rand_idle_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
